ov7670_capture: RTL and testbench

OV7670_CAPTURE -- requirements
Module: ov7670_capture

---
 rtl/ov7670_pkg.sv | 18 +
 rtl/ov7670_sync_edge.sv | 26 ++
 rtl/ov7670_capture.sv | 147 ++++++++++++++
 tb/tb_ov7670_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 camera capture path: default geometry,
// counter widths and the capture FSM state encoding.
package ov7670_pkg;

  localparam int OV_H_ACTIVE = 640;
  localparam int OV_V_ACTIVE = 480;
  localparam int OV_ADDR_W   = 19;

  // Wide enough for an over-long line (column) or an extra line (row).
  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SYNC      = 2'd1,
    ACTIVE    = 2'd2
  } cap_state_e;

endpackage

// File: rtl/ov7670_sync_edge.sv
// Rise/fall detector for a pclk-synchronous camera strobe. The previous sample
// is registered; edges compare it with the current input so they align with it.
module ov7670_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: assembles byte pairs into RGB444 pixels and writes
// them to a linear frame buffer, with optional 2:1 decimation in both axes.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = OV_H_ACTIVE,
  parameter int V_ACTIVE = OV_V_ACTIVE,
  parameter int ADDR_W   = OV_ADDR_W
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic              decimate,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [11:0]       wdata,
  output logic              frame_done,
  output logic              line_err,
  output logic              ovf
);

  localparam int                LIM_FULL_I = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LIM_FULL   = ADDR_W'(LIM_FULL_I);
  localparam logic [ADDR_W-1:0] LIM_DEC    = ADDR_W'(LIM_FULL_I / 4);

  logic vs_rise, vs_fall;
  logic href_fall, href_rise_unused;

  ov7670_sync_edge u_vsync_edge (
    .clk    (pclk),
    .rst_n  (rst_n),
    .sig_i  (vsync),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  ov7670_sync_edge u_href_edge (
    .clk    (pclk),
    .rst_n  (rst_n),
    .sig_i  (href),
    .rise_o (href_rise_unused),
    .fall_o (href_fall)
  );

  cap_state_e        state_q;
  logic              phase_q;
  logic [6:0]        hi_q;     // only the high-byte bits that survive RGB444
  logic [CNT_W-1:0]  col_q, row_q;
  logic [ADDR_W-1:0] wptr_q;   // next address to write
  logic              dec_q;
  logic              we_q, frame_done_q, line_err_q, ovf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [11:0]       wdata_q;

  logic              keep_pix;
  logic              at_limit;
  logic [ADDR_W-1:0] limit;

  assign limit    = dec_q ? LIM_DEC : LIM_FULL;
  assign keep_pix = !dec_q || (!col_q[0] && !row_q[0]);
  // Once the buffer is full every later write of the frame is dropped.
  assign at_limit = ovf_q || (wptr_q == limit);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_SYNC;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      wptr_q       <= '0;
      dec_q        <= 1'b0;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      ovf_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      case (state_q)
        WAIT_SYNC: begin
          phase_q <= 1'b0;
          if (vsync) state_q <= SYNC;
        end
        SYNC: begin
          phase_q <= 1'b0;
          if (vs_fall) begin
            state_q <= ACTIVE;
            col_q   <= '0;
            row_q   <= '0;
            wptr_q  <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            dec_q   <= decimate;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            // Frame ends even mid-line; a pending high byte is simply dropped.
            state_q      <= SYNC;
            frame_done_q <= 1'b1;
            phase_q      <= 1'b0;
          end else if (href) begin
            if (!phase_q) begin
              hi_q    <= {d[7:4], d[2:0]};
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              col_q   <= col_q + CNT_W'(1);
              if (keep_pix) begin
                if (at_limit) begin
                  ovf_q <= 1'b1;
                end else begin
                  we_q    <= 1'b1;
                  addr_q  <= wptr_q;
                  wdata_q <= {hi_q, d[7], d[4:1]};
                  wptr_q  <= wptr_q + ADDR_W'(1);
                end
              end
            end
          end else begin
            phase_q <= 1'b0;
            if (href_fall) begin
              line_err_q <= phase_q || (col_q != CNT_W'(H_ACTIVE));
              col_q      <= '0;
              row_q      <= row_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

  assign we         = we_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 8x6 geometry so complete
// frames, decimation and overflow stay short.
module tb_ov7670_capture;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 19;

  logic          pclk = 1'b0;
  logic          rst_n, vsync, href, decimate;
  logic [7:0]    d;
  logic          we, frame_done, line_err, ovf;
  logic [AW-1:0] addr;
  logic [11:0]   wdata;

  int checks = 0;
  int errors = 0;

  // Write log collected by a passive monitor on the falling edge.
  int            wr_cnt, fd_cnt, le_cnt;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] mon_addr [0:63];
  logic [11:0]   mon_data [0:63];

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .decimate   (decimate),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .frame_done (frame_done),
    .line_err   (line_err),
    .ovf        (ovf)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (we) begin
      if (wr_cnt < 64) begin
        mon_addr[wr_cnt] = addr;
        mon_data[wr_cnt] = wdata;
      end
      wr_cnt++;
      last_addr = addr;
    end
    if (frame_done) fd_cnt++;
    if (line_err)   le_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] pat(input int row, input int k);
    logic [7:0] v;
    v = 8'(row * 37 + k * 13 + 5);
    return v ^ 8'hA5;
  endfunction

  function automatic logic [11:0] exp_px(input int row, input int col);
    logic [7:0] hi, lo;
    hi = pat(row, 2 * col);
    lo = pat(row, 2 * col + 1);
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

  task automatic cyc();
    @(negedge pclk);
  endtask

  task automatic clear_mon();
    wr_cnt = 0;
    fd_cnt = 0;
    le_cnt = 0;
    last_addr = '0;
  endtask

  task automatic start_frame();
    vsync = 1'b1;
    repeat (3) cyc();
    vsync = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic end_frame();
    vsync = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic send_line(input int row, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      href = 1'b1;
      d    = pat(row, k);
      cyc();
    end
    href = 1'b0;
    d    = 8'h00;
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b1; href = 1'b1; d = 8'hFF; decimate = 1'b0;
    clear_mon();
    repeat (4) cyc();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
    checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", addr); end
    checks++; if (wdata !== 12'h000) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", wdata); end
    checks++; if ({frame_done, line_err, ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {frame_done, line_err, ovf}); end
    vsync = 1'b0; href = 1'b0; d = 8'h00;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Lines before the first vsync pulse belong to a partial frame.
  task automatic test_first_frame_discard();
    clear_mon();
    send_line(0, 2 * H);
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL discard_writes: got %0d expected 0", wr_cnt); end
  endtask

  task automatic test_single_line();
    clear_mon();
    decimate = 1'b0;
    start_frame();
    href = 1'b1; d = 8'hF8; cyc();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL line_we_hi0: got %b expected 0", we); end
    d = 8'h1F; cyc();
    checks++; if ({we, addr, wdata} !== {1'b1, 19'd0, 12'hF0F}) begin errors++; $display("FAIL line_px0: got we=%b addr=%0h wdata=%0h expected we=1 addr=0 wdata=f0f", we, addr, wdata); end
    d = 8'h07; cyc();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL line_we_hi1: got %b expected 0", we); end
    d = 8'hE0; cyc();
    checks++; if ({we, addr, wdata} !== {1'b1, 19'd1, 12'h0F0}) begin errors++; $display("FAIL line_px1: got we=%b addr=%0h wdata=%0h expected we=1 addr=1 wdata=0f0", we, addr, wdata); end
    href = 1'b0; d = 8'h00; cyc();
    checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL line_short_err: got %b expected 1", line_err); end
    cyc();
    end_frame();
    checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL line_writes: got %0d expected 2", wr_cnt); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL line_frame_done: got %0d expected 1", fd_cnt); end
  endtask

  task automatic test_full_frame();
    clear_mon();
    decimate = 1'b0;
    start_frame();
    for (int r = 0; r < V; r++) send_line(r, 2 * H);
    end_frame();
    checks++; if (wr_cnt !== H * V) begin errors++; $display("FAIL full_writes: got %0d expected %0d", wr_cnt, H * V); end
    checks++; if (last_addr !== AW'(H * V - 1)) begin errors++; $display("FAIL full_last_addr: got %0d expected %0d", last_addr, H * V - 1); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL full_frame_done: got %0d expected 1", fd_cnt); end
    checks++; if (le_cnt !== 0) begin errors++; $display("FAIL full_line_err: got %0d expected 0", le_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_ovf: got %b expected 0", ovf); end
    for (int i = 0; i < H * V; i++) begin
      checks++;
      if (mon_addr[i] !== AW'(i) || mon_data[i] !== exp_px(i / H, i % H)) begin
        errors++;
        $display("FAIL full_px%0d: got addr=%0d data=%0h expected addr=%0d data=%0h", i, mon_addr[i], mon_data[i], i, exp_px(i / H, i % H));
      end
    end
  endtask

  task automatic test_decimate();
    clear_mon();
    decimate = 1'b1;
    start_frame();
    decimate = 1'b0;  // ignored until the next frame entry
    for (int r = 0; r < V; r++) send_line(r, 2 * H);
    end_frame();
    checks++; if (wr_cnt !== (H * V) / 4) begin errors++; $display("FAIL dec_writes: got %0d expected %0d", wr_cnt, (H * V) / 4); end
    checks++; if (last_addr !== AW'((H * V) / 4 - 1)) begin errors++; $display("FAIL dec_last_addr: got %0d expected %0d", last_addr, (H * V) / 4 - 1); end
    for (int i = 0; i < (H * V) / 4; i++) begin
      checks++;
      if (mon_addr[i] !== AW'(i) || mon_data[i] !== exp_px(2 * (i / (H / 2)), 2 * (i % (H / 2)))) begin
        errors++;
        $display("FAIL dec_px%0d: got addr=%0d data=%0h expected addr=%0d data=%0h", i, mon_addr[i], mon_data[i], i, exp_px(2 * (i / (H / 2)), 2 * (i % (H / 2))));
      end
    end
  endtask

  task automatic test_long_line();
    clear_mon();
    decimate = 1'b0;
    start_frame();
    send_line(3, 2 * H + 1);
    checks++; if (le_cnt !== 1) begin errors++; $display("FAIL long_line_err: got %0d expected 1", le_cnt); end
    checks++; if (wr_cnt !== H) begin errors++; $display("FAIL long_writes: got %0d expected %0d", wr_cnt, H); end
    checks++; if (mon_data[H - 1] !== exp_px(3, H - 1)) begin errors++; $display("FAIL long_last_px: got %0h expected %0h", mon_data[H - 1], exp_px(3, H - 1)); end
    end_frame();
  endtask

  task automatic test_overflow();
    clear_mon();
    decimate = 1'b0;
    start_frame();
    for (int r = 0; r < V + 1; r++) send_line(r, 2 * H);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    checks++; if (wr_cnt !== H * V) begin errors++; $display("FAIL ovf_writes: got %0d expected %0d", wr_cnt, H * V); end
    checks++; if (addr !== AW'(H * V - 1)) begin errors++; $display("FAIL ovf_addr_hold: got %0d expected %0d", addr, H * V - 1); end
    end_frame();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    start_frame();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
    end_frame();
  endtask

  task automatic test_reset_midline();
    decimate = 1'b0;
    start_frame();
    for (int k = 0; k < 6; k++) begin
      href = 1'b1; d = pat(0, k); cyc();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({we, addr, wdata, frame_done, line_err, ovf} !== '0) begin errors++; $display("FAIL rstmid_outputs: got we=%b addr=%0h wdata=%0h expected all 0", we, addr, wdata); end
    clear_mon();
    cyc();
    d = pat(0, 6); cyc();
    rst_n = 1'b1;
    for (int k = 7; k < 2 * H; k++) begin
      d = pat(0, k); cyc();
    end
    href = 1'b0; d = 8'h00;
    repeat (3) cyc();
    send_line(1, 2 * H);
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rstmid_no_write: got %0d expected 0", wr_cnt); end
    start_frame();
    send_line(0, 2 * H);
    checks++; if (wr_cnt !== H) begin errors++; $display("FAIL rstmid_resume: got %0d expected %0d", wr_cnt, H); end
    checks++; if (last_addr !== AW'(H - 1)) begin errors++; $display("FAIL rstmid_last_addr: got %0d expected %0d", last_addr, H - 1); end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_first_frame_discard();
    test_single_line();
    test_full_frame();
    test_decimate();
    test_long_line();
    test_overflow();
    test_reset_midline();
    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
